// File: rtl/trafficlight_multi.sv
// Purpose: N-approach round-robin traffic controller with latched pedestrian phase and flashing night mode.
// Latency: every timed phase dwells T*FPGAFREQ cycles; button to sol_light is 3 clocks.
// Backpressure: none; free-running controller, inputs are sampled every cycle through synchronisers.
module trafficlight_multi #(
  parameter int FPGAFREQ   = 50_000_000,
  parameter int N_DIR      = 4,
  parameter int T_GREEN    = 18,
  parameter int T_YELLOW   = 4,
  parameter int T_ALLRED   = 1,
  parameter int T_PEDGREEN = 5,
  parameter int T_PEDCLEAR = 2,
  parameter int T_RESET    = 3
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     b_npeaton,
  input  logic                     night,
  output logic [3*N_DIR-1:0]       lights,
  output logic [1:0]               pea_lights,
  output logic                     sol_light,
  output logic [$clog2(N_DIR)-1:0] dir_idx
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DW   = $clog2(N_DIR);
  localparam int CW   = $clog2(FPGAFREQ + 1);
  localparam int TMAX = max2(max2(max2(T_GREEN, T_YELLOW), max2(T_ALLRED, T_PEDGREEN)),
                             max2(T_PEDCLEAR, T_RESET));
  localparam int SW   = $clog2(TMAX) + 1;
  localparam logic [DW-1:0] LAST = DW'(N_DIR - 1);

  typedef enum logic [2:0] {
    SRESET, SGREEN, SYELLOW, SALLRED, SPEDGREEN, SPEDCLEAR, SNIGHT
  } state_t;

  state_t          state, nxt_state, nxt_dec;
  logic            peat_s1, peat_s2, night_s1, night_s2;
  logic            b_peaton, night_q;
  logic [CW-1:0]   cnt_div;
  logic [SW-1:0]   cnt_sec;
  logic            sec_tick, expire, time_up;
  logic            solicitud, blink;

  // Seconds to load for a phase, minus one; night mode re-evaluates every second
  function automatic logic [SW-1:0] dur_m1(input state_t s);
    logic [SW-1:0] d;
    d = '0;
    case (s)
      SRESET:    d = SW'(T_RESET - 1);
      SGREEN:    d = SW'(T_GREEN - 1);
      SYELLOW:   d = SW'(T_YELLOW - 1);
      SALLRED:   d = SW'(T_ALLRED - 1);
      SPEDGREEN: d = SW'(T_PEDGREEN - 1);
      SPEDCLEAR: d = SW'(T_PEDCLEAR - 1);
      default:   d = '0;
    endcase
    return d;
  endfunction

  assign b_peaton  = peat_s2;
  assign night_q   = night_s2;
  assign sec_tick  = (cnt_div == CW'(FPGAFREQ - 1));
  assign expire    = sec_tick && (cnt_sec == '0);
  assign sol_light = solicitud;

  // Two-flop synchronisers; the button is stored already inverted (1 = pressed)
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      peat_s1  <= 1'b0;
      peat_s2  <= 1'b0;
      night_s1 <= 1'b0;
      night_s2 <= 1'b0;
    end else begin
      peat_s1  <= ~b_npeaton;
      peat_s2  <= peat_s1;
      night_s1 <= night;
      night_s2 <= night_s1;
    end
  end

  // Free-running 1 Hz divider
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) cnt_div <= '0;
    else         cnt_div <= sec_tick ? '0 : cnt_div + CW'(1);
  end

  // Successor phase, decided at the second boundary that ends the current phase
  always_comb begin
    nxt_dec = state;
    case (state)
      SRESET:    nxt_dec = SGREEN;
      SGREEN:    nxt_dec = SYELLOW;
      SYELLOW:   nxt_dec = SALLRED;
      SALLRED:   if (night_q)                              nxt_dec = SNIGHT;
                 else if (solicitud && (dir_idx == LAST))  nxt_dec = SPEDGREEN;
                 else                                      nxt_dec = SGREEN;
      SPEDGREEN: nxt_dec = SPEDCLEAR;
      SPEDCLEAR: nxt_dec = night_q ? SNIGHT : SGREEN;
      SNIGHT:    nxt_dec = night_q ? SNIGHT : SALLRED;
      default:   nxt_dec = SRESET;
    endcase
  end

  // Phase sequencer: decide and reload at the boundary, switch on the following time_up edge
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= SRESET;
      nxt_state <= SGREEN;
      time_up   <= 1'b0;
      cnt_sec   <= SW'(T_RESET - 1);
      dir_idx   <= '0;
      blink     <= 1'b0;
      solicitud <= 1'b0;
    end else begin
      time_up <= expire;
      if (sec_tick) begin
        if (cnt_sec == '0) begin
          nxt_state <= nxt_dec;
          cnt_sec   <= dur_m1(nxt_dec);
        end else begin
          cnt_sec <= cnt_sec - SW'(1);
        end
      end
      if (time_up) begin
        state <= nxt_state;
        case (nxt_state)
          SGREEN:  if (state == SALLRED) dir_idx <= (dir_idx == LAST) ? '0 : dir_idx + DW'(1);
                   else                  dir_idx <= '0;
          // Leaving night lands on the last approach so the next green is approach 0 or pedestrians
          SALLRED: if (state == SNIGHT) dir_idx <= LAST;
          SNIGHT:  blink <= (state == SNIGHT) ? ~blink : 1'b1;
          default: ;
        endcase
      end
      // Entry clear wins over a simultaneous press
      if (time_up && ((nxt_state == SPEDGREEN) || (nxt_state == SNIGHT)))
        solicitud <= 1'b0;
      else if (b_peaton && ((state == SGREEN) || (state == SYELLOW) || (state == SALLRED)))
        solicitud <= 1'b1;
    end
  end

  // Lamp decode from phase, owning approach and flash phase
  always_comb begin
    lights     = {N_DIR{3'b100}};
    pea_lights = 2'b10;
    case (state)
      SGREEN:    lights[3*dir_idx +: 3] = 3'b001;
      SYELLOW:   lights[3*dir_idx +: 3] = 3'b010;
      SPEDGREEN: pea_lights = 2'b01;
      SNIGHT:    lights = {N_DIR{1'b0, blink, 1'b0}};
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_trafficlight_multi.sv
// Purpose: randomized and directed bench for trafficlight_multi against a phase-timeline model.
// Latency: model tracks phase end times in absolute clock edges since reset release.
// Backpressure: none; inputs driven 1 time unit after each rising edge.
module tb_trafficlight_multi;

  localparam int F = 4;
  localparam int N = 3;
  localparam int PH_RESET = 0, PH_GREEN = 1, PH_YELLOW = 2, PH_ALLRED = 3,
                 PH_PEDG = 4, PH_PEDC = 5, PH_NIGHT = 6;
  localparam logic [8:0] ALLRED = 9'b100100100;
  localparam logic [8:0] G0     = 9'b100100001;
  localparam logic [8:0] Y0     = 9'b100100010;
  localparam logic [8:0] G1     = 9'b100001100;
  localparam logic [8:0] YALL   = 9'b010010010;
  localparam logic [8:0] DARK   = 9'b000000000;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       b_npeaton = 1'b1;
  logic       night = 1'b0;
  logic [8:0] lights;
  logic [1:0] pea_lights;
  logic       sol_light;
  logic [1:0] dir_idx;

  int checks = 0;
  int errors = 0;

  // model state: phase, absolute edge of next phase change, pending decision
  int k, m_phase, m_end, m_nxt, m_dir;
  bit m_sol, m_blink, m_pend, bd1, bd2, nd1, nd2;

  trafficlight_multi #(.FPGAFREQ(F), .N_DIR(N)) dut (
    .clk(clk), .nreset(nreset), .b_npeaton(b_npeaton), .night(night),
    .lights(lights), .pea_lights(pea_lights), .sol_light(sol_light), .dir_idx(dir_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic int ph_secs(input int p);
    case (p)
      PH_RESET:  return 3;
      PH_GREEN:  return 18;
      PH_YELLOW: return 4;
      PH_ALLRED: return 1;
      PH_PEDG:   return 5;
      PH_PEDC:   return 2;
      default:   return 1;
    endcase
  endfunction

  function automatic int next_phase(input int p, input bit ng, input bit sol, input int dir);
    case (p)
      PH_RESET:  return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_ALLRED;
      PH_ALLRED: return ng ? PH_NIGHT : ((sol && dir == N-1) ? PH_PEDG : PH_GREEN);
      PH_PEDG:   return PH_PEDC;
      PH_PEDC:   return ng ? PH_NIGHT : PH_GREEN;
      default:   return ng ? PH_NIGHT : PH_ALLRED;
    endcase
  endfunction

  function automatic logic [8:0] exp_lights();
    logic [8:0] r;
    for (int i = 0; i < N; i++) begin
      if (m_phase == PH_NIGHT)                      r[3*i +: 3] = {1'b0, m_blink, 1'b0};
      else if (m_phase == PH_GREEN && i == m_dir)   r[3*i +: 3] = 3'b001;
      else if (m_phase == PH_YELLOW && i == m_dir)  r[3*i +: 3] = 3'b010;
      else                                          r[3*i +: 3] = 3'b100;
    end
    return r;
  endfunction

  task automatic model_reset();
    k = 0; m_phase = PH_RESET; m_end = ph_secs(PH_RESET)*F + 1; m_nxt = PH_GREEN;
    m_dir = 0; m_sol = 0; m_blink = 0; m_pend = 0;
    bd1 = 0; bd2 = 0; nd1 = 0; nd2 = 0;
  endtask

  // One clock: advance DUT and model, then compare every output and the safety rules
  task automatic step();
    bit bn, ng, bp, ngs, old_sol, decide;
    int old, old_dir, gy;
    logic [8:0] el;
    logic [1:0] ep, ed;
    bit anyred, allred;
    bn = ~b_npeaton; ng = night;
    @(posedge clk);
    #1;
    k++;
    bp = bd2; ngs = nd2;
    bd2 = bd1; bd1 = bn; nd2 = nd1; nd1 = ng;
    old = m_phase; old_sol = m_sol; old_dir = m_dir;
    decide = (old == PH_NIGHT) ? (k % F == 0) : (k == m_end - 1);
    if (m_pend && (m_nxt == PH_PEDG || m_nxt == PH_NIGHT)) m_sol = 0;
    else if (bp && (old == PH_GREEN || old == PH_YELLOW || old == PH_ALLRED)) m_sol = 1;
    if (m_pend) begin
      if (m_nxt == PH_GREEN) m_dir = (old == PH_ALLRED) ? (old_dir + 1) % N : 0;
      if (m_nxt == PH_ALLRED && old == PH_NIGHT) m_dir = N - 1;
      if (m_nxt == PH_NIGHT) m_blink = (old == PH_NIGHT) ? !m_blink : 1'b1;
      m_phase = m_nxt;
      m_end = k + ph_secs(m_nxt) * F;
    end
    if (decide) m_nxt = next_phase(old, ngs, old_sol, old_dir);
    m_pend = decide;

    el = exp_lights();
    ep = (m_phase == PH_PEDG) ? 2'b01 : 2'b10;
    ed = m_dir[1:0];
    checks += 4;
    if (lights !== el) begin
      errors++; $display("FAIL lights edge %0d: got %b expected %b", k, lights, el);
    end
    if (pea_lights !== ep) begin
      errors++; $display("FAIL pea_lights edge %0d: got %b expected %b", k, pea_lights, ep);
    end
    if (sol_light !== m_sol) begin
      errors++; $display("FAIL sol_light edge %0d: got %b expected %b", k, sol_light, m_sol);
    end
    if (dir_idx !== ed) begin
      errors++; $display("FAIL dir_idx edge %0d: got %0d expected %0d", k, dir_idx, ed);
    end
    gy = 0; anyred = 0; allred = 1;
    for (int i = 0; i < N; i++) begin
      if (lights[3*i] || lights[3*i+1]) gy++;
      if (lights[3*i+2]) anyred = 1;
      if (lights[3*i +: 3] !== 3'b100) allred = 0;
    end
    checks += 2;
    if (anyred && gy > 1) begin
      errors++; $display("FAIL one_approach edge %0d: got %0d non-red approaches, required at most 1", k, gy);
    end
    if (pea_lights === 2'b01 && !allred) begin
      errors++; $display("FAIL ped_conflict edge %0d: pea_lights 01 with lights %b, required all red", k, lights);
    end
  endtask

  task automatic test_reset();
    nreset = 0; b_npeaton = 1; night = 0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (lights !== ALLRED) begin errors++; $display("FAIL reset_lights: got %b expected %b", lights, ALLRED); end
    if (pea_lights !== 2'b10) begin errors++; $display("FAIL reset_pea: got %b expected 10", pea_lights); end
    if (sol_light !== 1'b0) begin errors++; $display("FAIL reset_sol: got %b expected 0", sol_light); end
    if (dir_idx !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", dir_idx); end
    nreset = 1;
    model_reset();
    for (int i = 1; i <= 12; i++) step();
    checks++;
    if (lights !== ALLRED) begin errors++; $display("FAIL reset_dwell edge 12: got %b expected %b", lights, ALLRED); end
  endtask

  task automatic test_cycle();
    int g0, y0, g1, ped;
    g0 = 0; y0 = 0; g1 = 0; ped = 0;
    for (int i = 0; i < 276; i++) begin
      step();
      if (lights === G0) g0++;
      if (lights === Y0) y0++;
      if (lights === G1) g1++;
      if (pea_lights === 2'b01) ped++;
    end
    checks += 4;
    if (g0 != 72) begin errors++; $display("FAIL green0_len: got %0d expected 72", g0); end
    if (y0 != 16) begin errors++; $display("FAIL yellow0_len: got %0d expected 16", y0); end
    if (g1 != 72) begin errors++; $display("FAIL green1_len: got %0d expected 72", g1); end
    if (ped != 0) begin errors++; $display("FAIL no_ped_round: got %0d ped cycles expected 0", ped); end
    step();
    checks++;
    if (lights !== G0 || dir_idx !== 2'd0) begin
      errors++; $display("FAIL wrap_to_0: got lights %b dir %0d expected %b dir 0", lights, dir_idx, G0);
    end
  endtask

  task automatic test_ped();
    int n, pg, pc;
    n = 0;
    while (lights !== G1 && n < 400) begin step(); n++; end
    checks++;
    if (lights !== G1) begin errors++; $display("FAIL wait_green1: got %b expected %b", lights, G1); end
    repeat (5) step();
    b_npeaton = 0;
    step();
    b_npeaton = 1;
    step();
    checks++;
    if (sol_light !== 1'b0) begin errors++; $display("FAIL sol_early: got %b expected 0", sol_light); end
    step();
    checks++;
    if (sol_light !== 1'b1) begin errors++; $display("FAIL sol_latency3: got %b expected 1", sol_light); end
    n = 0;
    while (pea_lights !== 2'b01 && n < 400) begin step(); n++; end
    pg = 0;
    while (pea_lights === 2'b01 && pg < 40) begin
      pg++;
      checks++;
      if (sol_light !== 1'b0) begin errors++; $display("FAIL sol_clear_ped: got %b expected 0", sol_light); end
      step();
    end
    pc = 0;
    while (lights === ALLRED && pc < 40) begin pc++; step(); end
    checks += 3;
    if (pg != 20) begin errors++; $display("FAIL pedgreen_len: got %0d expected 20", pg); end
    if (pc != 8) begin errors++; $display("FAIL pedclear_len: got %0d expected 8", pc); end
    if (lights !== G0) begin errors++; $display("FAIL after_ped: got %b expected %b", lights, G0); end
  endtask

  task automatic test_night();
    int n, ny, nd, nr;
    repeat (5) step();
    night = 1;
    n = 0;
    while (lights !== YALL && n < 200) begin step(); n++; end
    ny = 0;
    while (lights === YALL && ny < 20) begin ny++; step(); end
    nd = 0;
    while (lights === DARK && nd < 20) begin nd++; step(); end
    checks += 2;
    if (ny != 4) begin errors++; $display("FAIL night_on_len: got %0d expected 4", ny); end
    if (nd != 4) begin errors++; $display("FAIL night_off_len: got %0d expected 4", nd); end
    b_npeaton = 0;
    step();
    b_npeaton = 1;
    repeat (4) step();
    checks++;
    if (sol_light !== 1'b0) begin errors++; $display("FAIL night_ignores_btn: got %b expected 0", sol_light); end
    night = 0;
    n = 0;
    while (lights !== ALLRED && n < 20) begin step(); n++; end
    nr = 0;
    while (lights === ALLRED && nr < 20) begin nr++; step(); end
    checks += 2;
    if (nr != 4) begin errors++; $display("FAIL night_exit_allred: got %0d expected 4", nr); end
    if (lights !== G0) begin errors++; $display("FAIL night_exit_green0: got %b expected %b", lights, G0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      b_npeaton = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 399) == 0) night = ~night;
      step();
    end
    night = 0; b_npeaton = 1;
    repeat (40) step();
  endtask

  task automatic test_reset_mid();
    int n;
    b_npeaton = 0;
    repeat (100) step();
    b_npeaton = 1;
    n = 0;
    while (pea_lights === 2'b01 && n < 40) begin step(); n++; end
    n = 0;
    while (pea_lights !== 2'b01 && n < 400) begin step(); n++; end
    repeat (3) step();
    checks++;
    if (pea_lights !== 2'b01) begin errors++; $display("FAIL reach_pedgreen: got %b expected 01", pea_lights); end
    nreset = 0;
    #1;
    checks += 4;
    if (lights !== ALLRED) begin errors++; $display("FAIL async_lights: got %b expected %b", lights, ALLRED); end
    if (pea_lights !== 2'b10) begin errors++; $display("FAIL async_pea: got %b expected 10", pea_lights); end
    if (sol_light !== 1'b0) begin errors++; $display("FAIL async_sol: got %b expected 0", sol_light); end
    if (dir_idx !== 2'd0) begin errors++; $display("FAIL async_dir: got %0d expected 0", dir_idx); end
    repeat (2) @(posedge clk);
    #1;
    nreset = 1;
    model_reset();
    for (int i = 1; i <= 13; i++) step();
    checks++;
    if (lights !== G0) begin errors++; $display("FAIL restart_green0 edge 13: got %b expected %b", lights, G0); end
    repeat (100) step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cycle();
    test_ped();
    test_night();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trafficlight_multi.md
# trafficlight_multi

Parametrised N-approach intersection controller, successor to the two-approach traffic light. Cycles green→yellow→all-red through `N_DIR` approaches in round-robin order. Serves a latched pedestrian request after the last approach. Adds a night mode in which all approaches flash yellow. Sits directly between the board clock/buttons and the LED outputs, with one 1 Hz time base derived internally from `clk`.

## Interface
Parameters:
- `FPGAFREQ`, 50_000_000: clock cycles per second.
- `N_DIR`, 4: number of vehicle approaches; must be ≥2.
- `T_GREEN`, 18: green time per approach, in seconds.
- `T_YELLOW`, 4: yellow time per approach, in seconds.
- `T_ALLRED`, 1: all-red clearance after each yellow, in seconds.
- `T_PEDGREEN`, 5: pedestrian walk time, in seconds.
- `T_PEDCLEAR`, 2: pedestrian clearance (all red), in seconds.
- `T_RESET`, 3: all-red time after reset, in seconds.
- All `T_*` must be ≥1.

Ports:
- `clk` in 1: system clock.
- `nreset` in 1: reset; asynchronous, active-low.
- `b_npeaton` in 1: pedestrian button, active-low, asynchronous to `clk`.
- `night` in 1: night-mode request, active-high, asynchronous to `clk`.
- `lights` out 3*N_DIR: approach i uses bits [3i+2:3i] = {red, yellow, green}.
- `pea_lights` out 2: {red, green}.
- `sol_light` out 1: pedestrian request pending.
- `dir_idx` out $clog2(N_DIR): approach currently owning green, yellow or all-red.

## Operation
- `b_npeaton` and `night` each pass through a 2-FF synchroniser. All decisions use the synchronised values (`b_peaton` is the inverted button).
- States: SRESET, SGREEN, SYELLOW, SALLRED, SPEDGREEN, SPEDCLEAR, SNIGHT.
- SRESET: all approaches red, `pea_lights`=10. After T_RESET → SGREEN with `dir_idx`=0.
- SGREEN: approach `dir_idx`=001, others 100, `pea_lights`=10. After T_GREEN → SYELLOW.
- SYELLOW: approach `dir_idx`=010, others 100. After T_YELLOW → SALLRED.
- SALLRED: all 100. At expiry, priority order:
  - `night` → SNIGHT.
  - else `solicitud` and `dir_idx`==N_DIR-1 → SPEDGREEN.
  - else SGREEN with `dir_idx` = `dir_idx`+1, wrapping N_DIR-1→0.
- SPEDGREEN: all approaches 100, `pea_lights`=01. After T_PEDGREEN → SPEDCLEAR.
- SPEDCLEAR: all 100, `pea_lights`=10. At expiry: `night` → SNIGHT, else SGREEN with `dir_idx`=0.
- SNIGHT: every approach shows {0,`blink`,0}; `pea_lights`=10.
  - `blink` is set to 1 on entry and toggles at every second boundary.
  - At each second boundary with `night`=0 → SALLRED for T_ALLRED with `dir_idx` forced to N_DIR-1, so the next green is approach 0 or the pedestrian phase.
- Pedestrian request (`solicitud`):
  - Set while `b_peaton`=1 in SGREEN, SYELLOW or SALLRED.
  - Cleared on entry to SPEDGREEN and on entry to SNIGHT.
  - Ignored in SRESET, SPEDGREEN, SPEDCLEAR and SNIGHT.
  - `sol_light` = `solicitud`, registered.
- Outputs are a combinational decode of state, `dir_idx` and `blink`. Exactly one approach is non-red in SGREEN/SYELLOW; never two.

## Timing
- Divider `cnt_div` counts 0..FPGAFREQ-1, free-running from reset. A second boundary is the cycle where `cnt_div`==FPGAFREQ-1.
- Seconds counter `cnt_sec` has width $clog2(max T)+1.
  - It is loaded with T_next-1 at the boundary where the current count is 0.
  - A registered `time_up` pulse is asserted in the following cycle, and the state changes on that same edge. Every timed state therefore dwells exactly T·FPGAFREQ cycles.
- Reset values:
  - State SRESET; `cnt_div`=0; `cnt_sec`=T_RESET-1.
  - `dir_idx`=0; `solicitud`=0; `blink`=0; synchronisers 0.
  - `lights` all red; `pea_lights`=10; `sol_light`=0.
- The first transition (SRESET→SGREEN) happens T_RESET·FPGAFREQ+1 rising edges after `nreset` deasserts.
- Button-to-`sol_light` latency: 3 clocks (2 synchroniser, 1 register).
- `night` change seen at a second boundary acts within 2 clocks plus the remaining time of that second. In timed states it acts only at that state's expiry.
- `nreset` asserted mid-operation clears everything immediately and asynchronously; no clock is required.

## Test plan
- FPGAFREQ=4, N_DIR=3, defaults otherwise. Release reset → SRESET for 12 cycles, then approach 0 = 001 for 72 cycles, 010 for 16, all-red for 4, then approach 1 green. `dir_idx` goes 0→1→2→0 with no pedestrian phase.
- Pulse `b_npeaton` low for 1 cycle during approach 1 green → `sol_light`=1 3 cycles later. After approach 2 all-red: `pea_lights`=01 for 20 cycles and `sol_light`=0, then 10 for 8 cycles, then approach 0 green.
- Assert `night` during approach 0 green → phases continue to the end of approach 0 all-red, then all approaches show yellow toggling every 4 cycles starting at 1. A button press during SNIGHT leaves `sol_light`=0.
- Deassert `night` in SNIGHT → at the next second boundary, all-red for 4 cycles, then approach 0 green. If `solicitud` was set, the pedestrian phase runs first.
- Assert `nreset`=0 mid-SPEDGREEN → in the same cycle `lights` all red, `pea_lights`=10, `sol_light`=0, `dir_idx`=0. The restart sequence matches the first scenario.
- Every cycle, check that at most one approach has green or yellow set, and that `pea_lights`=01 only while all approaches are red.
